// File: rtl/udp_pkg.sv
// udp_pkg: shared UDP path definitions (FSM encoding, header size).
// Used by both the receive and transmit UDP paths.
package udp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } udp_state_e;

    localparam int unsigned UDP_HDR_BYTES = 8;

endpackage

// File: rtl/udp_rx_byte_packer.sv
// udp_rx_byte_packer: packs a byte stream MSB-first into DATA_W words.
// Ports: i_valid/i_data/i_last/i_user byte in, o_* registered word out.
module udp_rx_byte_packer #(
    parameter  int DATA_W = 64,
    localparam int KEEP_W = DATA_W / 8,
    localparam int IDX_W  = $clog2(KEEP_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [7:0]        i_data,
    input  logic              i_last,
    input  logic              i_user,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_user
);

    logic [DATA_W-1:0] r_acc;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              r_valid;
    logic              r_last;
    logic              r_user;

    logic [DATA_W-1:0] w_acc;
    logic [KEEP_W-1:0] w_keep;
    logic [IDX_W:0]    w_nlanes;
    logic              w_full;
    logic              w_load;

    always_comb begin
        w_acc = r_acc;
        for (int i = 0; i < KEEP_W; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_acc[DATA_W-1-8*i -: 8] = i_data;
            end
        end
    end

    // Lanes 0..r_idx valid, lane 0 at the MSB end.
    assign w_nlanes = {1'b0, r_idx} + 1'b1;
    assign w_keep   = ~({KEEP_W{1'b1}} >> w_nlanes);
    assign w_full   = (r_idx == IDX_W'(KEEP_W - 1));
    assign w_load   = i_valid && (w_full || i_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_user  <= 1'b0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
                r_idx <= '0;
            end else if (i_valid) begin
                // Clearing on load keeps unused lanes of the next word zero.
                if (w_load) begin
                    r_acc <= '0;
                    r_idx <= '0;
                end else begin
                    r_acc <= w_acc;
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_acc;
                r_keep  <= w_keep;
                r_last  <= i_last;
                r_user  <= i_user;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_user  = r_user;

endmodule

// File: rtl/udp_rx_path.sv
// udp_rx_path: filters UDP packets on local IP/port, packs payload to words.
// Ports: rx_udp_hdr_* / rx_udp_payload_axis_* in, dout_* out, drop_count.
module udp_rx_path
    import udp_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_udp_hdr_valid,
    output logic              rx_udp_hdr_ready,
    input  logic [31:0]       rx_udp_ip_dest_ip,
    input  logic [15:0]       rx_udp_dest_port,
    input  logic [15:0]       rx_udp_length,
    input  logic [7:0]        rx_udp_payload_axis_tdata,
    input  logic              rx_udp_payload_axis_tvalid,
    output logic              rx_udp_payload_axis_tready,
    input  logic              rx_udp_payload_axis_tlast,
    input  logic              rx_udp_payload_axis_tuser,
    input  logic [31:0]       local_ip,
    input  logic [15:0]       local_port,
    output logic [DATA_W-1:0] dout_data,
    output logic [KEEP_W-1:0] dout_keep,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              dout_user,
    output logic [15:0]       drop_count
);

    udp_state_e  r_state;
    udp_state_e  w_state_nxt;
    logic        r_hdr_ready;
    logic [15:0] r_exp_len;
    logic [15:0] r_rx_count;
    logic [15:0] r_drop_count;

    logic        w_hdr_fire;
    logic        w_match;
    logic        w_tready;
    logic        w_beat;
    logic        w_pkt_beat;
    logic        w_drop_last;
    logic [15:0] w_rx_cnt_nxt;
    logic        w_user;
    logic        w_last_pend_nxt;

    assign w_match = (rx_udp_ip_dest_ip == local_ip) &&
                     (rx_udp_dest_port == local_port);
    assign w_hdr_fire = (r_state == IDLE) && r_hdr_ready &&
                        rx_udp_hdr_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_tready    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_hdr_fire) begin
                    w_state_nxt = w_match ? PAYLOAD : DROP;
                end
            end
            PAYLOAD: begin
                w_tready = !dout_valid || dout_ready;
                if (rx_udp_payload_axis_tvalid && w_tready &&
                    rx_udp_payload_axis_tlast) begin
                    w_state_nxt = IDLE;
                end
            end
            DROP: begin
                w_tready = 1'b1;
                if (rx_udp_payload_axis_tvalid &&
                    rx_udp_payload_axis_tlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_beat       = rx_udp_payload_axis_tvalid && w_tready;
    assign w_pkt_beat   = w_beat && (r_state == PAYLOAD);
    assign w_drop_last  = w_beat && (r_state == DROP) &&
                          rx_udp_payload_axis_tlast;
    assign w_rx_cnt_nxt = r_rx_count + 16'd1;
    assign w_user       = rx_udp_payload_axis_tlast &&
                          (rx_udp_payload_axis_tuser ||
                           (w_rx_cnt_nxt != r_exp_len));

    // A last word is still owed downstream after this edge.
    assign w_last_pend_nxt = (w_pkt_beat && rx_udp_payload_axis_tlast) ||
                             (dout_valid && dout_last && !dout_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_hdr_ready  <= 1'b0;
            r_exp_len    <= '0;
            r_rx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hdr_ready <= (w_state_nxt == IDLE) && !w_last_pend_nxt;
            if (w_hdr_fire && w_match) begin
                // Lengths below the header size wrap on purpose.
                r_exp_len  <= rx_udp_length - 16'(UDP_HDR_BYTES);
                r_rx_count <= '0;
            end else if (w_pkt_beat) begin
                r_rx_count <= w_rx_cnt_nxt;
            end
            if (w_drop_last && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    udp_rx_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_hdr_fire && w_match),
        .i_valid (w_pkt_beat),
        .i_data  (rx_udp_payload_axis_tdata),
        .i_last  (rx_udp_payload_axis_tlast),
        .i_user  (w_user),
        .i_ready (dout_ready),
        .o_data  (dout_data),
        .o_keep  (dout_keep),
        .o_valid (dout_valid),
        .o_last  (dout_last),
        .o_user  (dout_user)
    );

    assign rx_udp_hdr_ready           = r_hdr_ready;
    assign rx_udp_payload_axis_tready = w_tready;
    assign drop_count                 = r_drop_count;

endmodule

// File: tb/tb_udp_rx_path.sv
// tb_udp_rx_path: randomized self-checking bench for udp_rx_path.
// Reference model packs the byte list directly into expected words.
module tb_udp_rx_path;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam logic [31:0] LIP   = 32'hC0A80164;
    localparam logic [15:0] LPORT = 16'd1234;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_udp_hdr_valid;
    logic          rx_udp_hdr_ready;
    logic [31:0]   rx_udp_ip_dest_ip;
    logic [15:0]   rx_udp_dest_port;
    logic [15:0]   rx_udp_length;
    logic [7:0]    tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;
    logic [31:0]   local_ip;
    logic [15:0]   local_port;
    logic [DW-1:0] dout_data;
    logic [KW-1:0] dout_keep;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          dout_user;
    logic [15:0]   drop_count;

    int total = 0;
    int bad   = 0;
    word_t outq[$];
    word_t prev;
    bit    prev_stall = 0;
    logic [15:0] exp_drops = '0;

    always #5 clk = ~clk;

    udp_rx_path #(.DATA_W(DW)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .rx_udp_hdr_valid           (rx_udp_hdr_valid),
        .rx_udp_hdr_ready           (rx_udp_hdr_ready),
        .rx_udp_ip_dest_ip          (rx_udp_ip_dest_ip),
        .rx_udp_dest_port           (rx_udp_dest_port),
        .rx_udp_length              (rx_udp_length),
        .rx_udp_payload_axis_tdata  (tdata),
        .rx_udp_payload_axis_tvalid (tvalid),
        .rx_udp_payload_axis_tready (tready),
        .rx_udp_payload_axis_tlast  (tlast),
        .rx_udp_payload_axis_tuser  (tuser),
        .local_ip                   (local_ip),
        .local_port                 (local_port),
        .dout_data                  (dout_data),
        .dout_keep                  (dout_keep),
        .dout_valid                 (dout_valid),
        .dout_ready                 (dout_ready),
        .dout_last                  (dout_last),
        .dout_user                  (dout_user),
        .drop_count                 (drop_count)
    );

    // Output monitor: collects accepted words, checks hold while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                total++;
                if (dout_valid !== 1'b1 || dout_data !== prev.d ||
                    dout_keep !== prev.k || dout_last !== prev.l ||
                    dout_user !== prev.u) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b d=%h k=%h want v=1 d=%h k=%h",
                             dout_valid, dout_data, dout_keep, prev.d, prev.k);
                end
            end
            if (dout_valid && dout_ready) begin
                outq.push_back('{dout_data, dout_keep, dout_last, dout_user});
            end
            prev_stall = dout_valid && !dout_ready;
            prev = '{dout_data, dout_keep, dout_last, dout_user};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_ready(input bit rnd);
        dout_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic send_hdr(input logic [31:0] ip, input logic [15:0] port,
                            input logic [15:0] len);
        bit ok = 0;
        rx_udp_hdr_valid  = 1'b1;
        rx_udp_ip_dest_ip = ip;
        rx_udp_dest_port  = port;
        rx_udp_length     = len;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (rx_udp_hdr_ready) begin
                ok = 1;
                total++;
                if (tready !== 1'b0) begin
                    bad++;
                    $display("FAIL hdr_tready: got %b want 0", tready);
                end
            end
            @(posedge clk); #1;
        end
        rx_udp_hdr_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hdr_timeout: got no hdr_ready want hdr_ready=1");
        end
    endtask

    task automatic send_bytes(input bq_t b, input int upto, input bit user,
                              input bit rnd);
        int i = 0;
        int c = 0;
        while (i < upto && c < 2000) begin
            tvalid = 1'b1;
            tdata  = b[i];
            tlast  = (i == b.size() - 1);
            tuser  = user && (i == b.size() - 1);
            drive_ready(rnd);
            @(negedge clk);
            if (tready) i++;
            @(posedge clk); #1;
            c++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
        if (i < upto) begin
            total++;
            bad++;
            $display("FAIL byte_timeout: got %0d bytes want %0d", i, upto);
        end
    endtask

    // Sends one packet and checks the words against the reference model.
    task automatic run_pkt(input string name, input logic [15:0] port,
                           input logic [15:0] len, input bq_t b,
                           input bit user, input bit rnd);
        bit match = (port == LPORT);
        int n = b.size();
        int nw = match ? (n + KW - 1) / KW : 0;
        logic [15:0] plen = len - 16'd8;
        outq.delete();
        send_hdr(LIP, port, len);
        send_bytes(b, n, user, rnd);
        for (int c = 0; c < 500 && outq.size() < nw; c++) begin
            drive_ready(rnd);
            @(posedge clk); #1;
        end
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (outq.size() != nw) begin
            bad++;
            $display("FAIL %s_count: got %0d words want %0d", name,
                     outq.size(), nw);
        end
        if (!match) begin
            if (exp_drops != 16'hFFFF) exp_drops++;
            total++;
            if (drop_count !== exp_drops) begin
                bad++;
                $display("FAIL %s_drops: got %0d want %0d", name,
                         drop_count, exp_drops);
            end
        end
        for (int w = 0; w < nw && outq.size() > 0; w++) begin
            word_t e;
            word_t g = outq.pop_front();
            e.d = '0;
            e.k = '0;
            for (int j = 0; j < KW; j++) begin
                if (w * KW + j < n) begin
                    e.d[DW-1-8*j -: 8] = b[w * KW + j];
                    e.k[KW-1-j] = 1'b1;
                end
            end
            e.l = (w == nw - 1);
            e.u = e.l && (user || (n != int'(plen)));
            total++;
            if (g.d !== e.d || g.k !== e.k || g.l !== e.l || g.u !== e.u) begin
                bad++;
                $display("FAIL %s_word%0d: got d=%h k=%h l=%b u=%b want d=%h k=%h l=%b u=%b",
                         name, w, g.d, g.k, g.l, g.u, e.d, e.k, e.l, e.u);
            end
        end
    endtask

    task automatic seq_bytes(input logic [7:0] first, input int n,
                             output bq_t b);
        b = {};
        for (int i = 0; i < n; i++) b.push_back(first + 8'(i));
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if (rx_udp_hdr_ready !== 1'b0 || tready !== 1'b0 ||
            dout_valid !== 1'b0 || dout_last !== 1'b0 ||
            dout_user !== 1'b0 || dout_data !== '0 ||
            dout_keep !== '0 || drop_count !== 16'd0) begin
            bad++;
            $display("FAIL %s: got hr=%b tr=%b v=%b l=%b u=%b d=%h k=%h dc=%0d want all 0",
                     name, rx_udp_hdr_ready, tready, dout_valid, dout_last,
                     dout_user, dout_data, dout_keep, drop_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_vals");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (rx_udp_hdr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_hdr_ready: got %b want 1", rx_udp_hdr_ready);
        end
    endtask

    task automatic test_basic();
        bq_t b;
        seq_bytes(8'h00, 16, b);
        run_pkt("basic", LPORT, 16'd24, b, 1'b0, 1'b0);
    endtask

    task automatic test_short();
        bq_t b;
        seq_bytes(8'hAA, 11, b);
        run_pkt("short", LPORT, 16'd19, b, 1'b0, 1'b0);
    endtask

    task automatic test_drop();
        bq_t b;
        seq_bytes(8'h40, 20, b);
        run_pkt("drop", 16'd5678, 16'd28, b, 1'b0, 1'b0);
        seq_bytes(8'h10, 9, b);
        run_pkt("after_drop", LPORT, 16'd17, b, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        bq_t b;
        for (int i = 0; i < 64; i++) b.push_back(8'($urandom));
        run_pkt("stall", LPORT, 16'd72, b, 1'b0, 1'b1);
    endtask

    task automatic test_errors();
        bq_t b;
        seq_bytes(8'h20, 12, b);
        run_pkt("len_err", LPORT, 16'd16, b, 1'b0, 1'b0);
        run_pkt("tuser_err", LPORT, 16'd20, b, 1'b1, 1'b0);
        seq_bytes(8'h60, 3, b);
        run_pkt("underflow", LPORT, 16'd4, b, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bq_t b;
        seq_bytes(8'h80, 16, b);
        send_hdr(LIP, LPORT, 16'd24);
        send_bytes(b, 5, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        exp_drops = '0;
        check_idle_outputs("midreset_vals");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        outq.delete();
        @(posedge clk); #1;
        total++;
        if (rx_udp_hdr_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_hdr_ready: got %b want 1", rx_udp_hdr_ready);
        end
        run_pkt("after_reset", LPORT, 16'd24, b, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 12; p++) begin
            bq_t b;
            int n = $urandom_range(1, 40);
            logic [15:0] port = ($urandom_range(0, 3) == 0) ? 16'd999 : LPORT;
            logic [15:0] len = 16'(n + 8);
            bit user = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) len = 16'($urandom_range(0, 50));
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            run_pkt($sformatf("rand%0d", p), port, len, b, user, 1'b1);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        rx_udp_hdr_valid  = 1'b0;
        rx_udp_ip_dest_ip = '0;
        rx_udp_dest_port  = '0;
        rx_udp_length     = '0;
        tdata             = '0;
        tvalid            = 1'b0;
        tlast             = 1'b0;
        tuser             = 1'b0;
        dout_ready        = 1'b1;
        local_ip          = LIP;
        local_port        = LPORT;
        test_reset();
        test_basic();
        test_short();
        test_drop();
        test_stall();
        test_errors();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
